// File: rtl/snake_body.sv
// snake_body: snake segment store with wall/self collision and occupancy query.
// Optional feature macro: SNAKE_WRAP_EN (toroidal grid, no wall death).
// seg[0] is the head; only seg[0..len-1] are valid.
module snake_body #(
    parameter int MAX_LEN   = 32,
    parameter int INIT_LEN  = 3,
    parameter int GRID_ROWS = 30,
    parameter int GRID_COLS = 40,
    parameter int START_X   = 15,
    parameter int START_Y   = 20
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Tick,
    input  logic [5:0] i_New_x,
    input  logic [5:0] i_New_y,
    input  logic       i_Grow,
    input  logic [5:0] i_Qry_x,
    input  logic [5:0] i_Qry_y,
    output logic [5:0] o_Head_x,
    output logic [5:0] o_Head_y,
    output logic [5:0] o_Len,
    output logic       o_Hit,
    output logic       o_Hit_Head,
    output logic       o_Dead,
    output logic       o_Running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nx_s;
    logic [5:0] seg_x_r [MAX_LEN];
    logic [5:0] seg_y_r [MAX_LEN];
    logic [5:0] len_r;
    logic       hit_r;
    logic       hit_head_r;
    logic       dead_r;
    logic       running_r;

    logic [5:0] new_x_s;
    logic [5:0] new_y_s;
    logic       wall_s;
    logic       self_s;
    logic [5:0] lim_s;
    logic       tick_s;
    logic       collide_s;
    logic       move_s;
    logic       hit_s;

    // Map the proposed head onto the grid (wrap build) or flag it as leaving the grid.
    always_comb begin
        new_x_s = i_New_x;
        new_y_s = i_New_y;
        wall_s  = 1'b0;
`ifdef SNAKE_WRAP_EN
        if (i_New_x == 6'd63) begin
            new_x_s = 6'(GRID_ROWS - 1);
        end else if (i_New_x == 6'(GRID_ROWS)) begin
            new_x_s = 6'd0;
        end else begin
            new_x_s = i_New_x;
        end
        if (i_New_y == 6'd63) begin
            new_y_s = 6'(GRID_COLS - 1);
        end else if (i_New_y == 6'(GRID_COLS)) begin
            new_y_s = 6'd0;
        end else begin
            new_y_s = i_New_y;
        end
`else
        // An upstream -1 arrives as 63 and is caught by the same compare.
        if ((i_New_x >= 6'(GRID_ROWS)) || (i_New_y >= 6'(GRID_COLS))) begin
            wall_s = 1'b1;
        end else begin
            wall_s = 1'b0;
        end
`endif
    end

    // Self collision: the tail cell is free unless the snake grows this move.
    always_comb begin
        lim_s  = i_Grow ? len_r : (len_r - 6'd1);
        self_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((6'(i) < lim_s) && (seg_x_r[i] == new_x_s) && (seg_y_r[i] == new_y_s)) begin
                self_s = 1'b1;
            end else begin
                self_s = self_s;
            end
        end
    end

    // Move qualification; a start in the same cycle drops the tick.
    always_comb begin
        tick_s    = (state_r == ST_RUN) && i_Tick && !i_Start;
        collide_s = tick_s && (wall_s || self_s);
        move_s    = tick_s && !collide_s;
    end

    // Next-state logic for IDLE / RUN / DEAD.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_Start) state_nx_s = ST_RUN;
                else         state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (i_Start)        state_nx_s = ST_RUN;
                else if (collide_s) state_nx_s = ST_DEAD;
                else                state_nx_s = ST_RUN;
            end
            ST_DEAD: begin
                if (i_Start) state_nx_s = ST_RUN;
                else         state_nx_s = ST_DEAD;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Occupancy of the queried cell over the valid segments.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((6'(i) < len_r) && (seg_x_r[i] == i_Qry_x) && (seg_y_r[i] == i_Qry_y)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // State register with registered status flags.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state_r   <= ST_IDLE;
            dead_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            dead_r    <= (state_nx_s == ST_DEAD);
            running_r <= (state_nx_s == ST_RUN);
        end
    end

    // Segment array and length: load initial pose, or shift in the new head.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst || i_Start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x_r[i] <= 6'(START_X);
                    seg_y_r[i] <= 6'(START_Y - i);
                end else begin
                    seg_x_r[i] <= 6'd0;
                    seg_y_r[i] <= 6'd0;
                end
            end
            len_r <= 6'(INIT_LEN);
        end else if (move_s) begin
            seg_x_r[0] <= new_x_s;
            seg_y_r[0] <= new_y_s;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_r[i] <= seg_x_r[i-1];
                seg_y_r[i] <= seg_y_r[i-1];
            end
            // The shift already copies the old tail one slot down; growing keeps it.
            if (i_Grow && (len_r < 6'(MAX_LEN))) len_r <= len_r + 6'd1;
            else                                 len_r <= len_r;
        end else begin
            len_r <= len_r;
        end
    end

    // Registered query answers, live in every state so a frozen body still renders.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            hit_r      <= 1'b0;
            hit_head_r <= 1'b0;
        end else begin
            hit_r      <= hit_s;
            hit_head_r <= (seg_x_r[0] == i_Qry_x) && (seg_y_r[0] == i_Qry_y);
        end
    end

    assign o_Head_x   = seg_x_r[0];
    assign o_Head_y   = seg_y_r[0];
    assign o_Len      = len_r;
    assign o_Hit      = hit_r;
    assign o_Hit_Head = hit_head_r;
    assign o_Dead     = dead_r;
    assign o_Running  = running_r;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed + randomized bench for snake_body against a list-based model.
// Two instances share the stimulus: default MAX_LEN=32 and MAX_LEN=4 (saturation).
`timescale 1ns/1ps
module tb_snake_body;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [5:0] new_x = 6'd0;
    logic [5:0] new_y = 6'd0;
    logic       grow = 1'b0;
    logic [5:0] qry_x = 6'd0;
    logic [5:0] qry_y = 6'd0;

    logic [5:0] hx0, hy0, len0, hx1, hy1, len1;
    logic       hit0, hh0, dead0, run0, hit1, hh1, dead1, run1;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model: per instance, a list of cells (code x*64+y), head first.
    int bd [2][64];
    int mlen [2];
    bit mrun [2];
    bit mdead [2];
    bit mhit [2];
    bit mhh [2];
    int maxl [2];

    always #5 clk = ~clk;

    snake_body u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Tick(tick),
        .i_New_x(new_x), .i_New_y(new_y), .i_Grow(grow),
        .i_Qry_x(qry_x), .i_Qry_y(qry_y),
        .o_Head_x(hx0), .o_Head_y(hy0), .o_Len(len0), .o_Hit(hit0),
        .o_Hit_Head(hh0), .o_Dead(dead0), .o_Running(run0)
    );

    snake_body #(.MAX_LEN(4)) u_sat (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Tick(tick),
        .i_New_x(new_x), .i_New_y(new_y), .i_Grow(grow),
        .i_Qry_x(qry_x), .i_Qry_y(qry_y),
        .o_Head_x(hx1), .o_Head_y(hy1), .o_Len(len1), .o_Hit(hit1),
        .o_Hit_Head(hh1), .o_Dead(dead1), .o_Running(run1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int wrap_coord(input int v, input int lim);
        int r;
        r = v;
`ifdef SNAKE_WRAP_EN
        if (v == 63) r = lim - 1;
        else if (v == lim) r = 0;
`endif
        return r;
    endfunction

    task automatic model_pose(input int k);
        for (int j = 0; j < 64; j++) bd[k][j] = (j < 3) ? (15 * 64 + 20 - j) : 0;
        mlen[k] = 3;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        int qc, nx, ny, c, lim;
        bit wall, self_hit;
        qc = int'(qry_x) * 64 + int'(qry_y);
        for (int k = 0; k < 2; k++) begin
            mhit[k] = 1'b0;
            for (int j = 0; j < mlen[k]; j++) if (bd[k][j] == qc) mhit[k] = 1'b1;
            mhh[k] = (bd[k][0] == qc);
            if (!rst) begin
                model_pose(k);
                mrun[k] = 1'b0; mdead[k] = 1'b0; mhit[k] = 1'b0; mhh[k] = 1'b0;
            end else if (start) begin
                model_pose(k);
                mrun[k] = 1'b1; mdead[k] = 1'b0;
            end else if (mrun[k] && tick) begin
                nx = wrap_coord(int'(new_x), 30);
                ny = wrap_coord(int'(new_y), 40);
`ifdef SNAKE_WRAP_EN
                wall = 1'b0;
`else
                wall = (nx >= 30) || (ny >= 40);
`endif
                c = nx * 64 + ny;
                lim = grow ? mlen[k] : mlen[k] - 1;
                self_hit = 1'b0;
                for (int j = 0; j < lim; j++) if (bd[k][j] == c) self_hit = 1'b1;
                if (wall || self_hit) begin
                    mrun[k] = 1'b0; mdead[k] = 1'b1;
                end else begin
                    for (int j = 63; j > 0; j--) bd[k][j] = bd[k][j-1];
                    bd[k][0] = c;
                    if (grow && mlen[k] < maxl[k]) mlen[k] = mlen[k] + 1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_tick(input int x, input int y, input bit g);
        tick = 1'b1; new_x = 6'(x); new_y = 6'(y); grow = g;
        cycle();
        tick = 1'b0; grow = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic query(input int x, input int y);
        qry_x = 6'(x); qry_y = 6'(y);
        cycle();
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("head0", int'(hx0) * 64 + int'(hy0), bd[0][0]);
                check("len0", int'(len0), mlen[0]);
                check("run0", int'(run0), int'(mrun[0]));
                check("dead0", int'(dead0), int'(mdead[0]));
                check("hit0", int'(hit0), int'(mhit[0]));
                check("hhead0", int'(hh0), int'(mhh[0]));
                check("head1", int'(hx1) * 64 + int'(hy1), bd[1][0]);
                check("len1", int'(len1), mlen[1]);
                check("run1", int'(run1), int'(mrun[1]));
                check("dead1", int'(dead1), int'(mdead[1]));
                check("hit1", int'(hit1), int'(mhit[1]));
                check("hhead1", int'(hh1), int'(mhh[1]));
            end
        end
    end

    task automatic build_square(input bit final_grow);
        do_start();
        do_tick(6, 5, 1'b1);
        do_tick(6, 6, 1'b0);
        do_tick(5, 6, 1'b0);
        do_tick(5, 5, 1'b0);
        do_tick(6, 5, final_grow);
    endtask

    initial begin
        int dir, hx, hy, j;
        maxl[0] = 32; maxl[1] = 4;
        for (int k = 0; k < 2; k++) begin
            model_pose(k); mrun[k] = 0; mdead[k] = 0; mhit[k] = 0; mhh[k] = 0;
        end
        rst = 1'b0;
        cycle();
        chk_en = 1'b1;
        cycle();
        rst = 1'b1;

        // Reset pose queries.
        query(15, 20);
        check("rst_hit_head_cell", int'(hit0), 1);
        check("rst_hhead_head_cell", int'(hh0), 1);
        check("rst_len", int'(len0), 3);
        check("rst_running", int'(run0), 0);
        check("rst_head", int'(hx0) * 64 + int'(hy0), 15 * 64 + 20);
        query(15, 18);
        check("rst_hit_tail", int'(hit0), 1);
        check("rst_hhead_tail", int'(hh0), 0);
        query(15, 17);
        check("rst_hit_outside", int'(hit0), 0);

        // Three moves with growth on the second.
        do_start();
        check("start_running", int'(run0), 1);
        do_tick(15, 21, 1'b0);
        do_tick(15, 22, 1'b1);
        do_tick(15, 23, 1'b0);
        check("grow_len", int'(len0), 4);
        check("grow_head", int'(hx0) * 64 + int'(hy0), 15 * 64 + 23);
        query(15, 20);
        check("grow_tail_kept", int'(hit0), 1);
        query(15, 19);
        check("grow_old_tail_gone", int'(hit0), 0);

        // Leaving the left edge (y = -1 -> 63).
        do_tick(15, 63, 1'b0);
`ifdef SNAKE_WRAP_EN
        check("wrap_alive", int'(dead0), 0);
        check("wrap_head", int'(hx0) * 64 + int'(hy0), 15 * 64 + 39);
`else
        check("wall_dead", int'(dead0), 1);
        check("wall_frozen", int'(hx0) * 64 + int'(hy0), 15 * 64 + 23);
        do_tick(15, 24, 1'b0);
        check("dead_tick_ignored", int'(hx0) * 64 + int'(hy0), 15 * 64 + 23);
        query(15, 21);
        check("dead_query", int'(hit0), 1);
`endif

        // Square: the tail cell is enterable only when not growing.
        build_square(1'b0);
        check("square_alive", int'(dead0), 0);
        check("square_head", int'(hx0) * 64 + int'(hy0), 6 * 64 + 5);
        build_square(1'b1);
        check("square_grow_dead", int'(dead0), 1);

        // Saturation on the MAX_LEN=4 instance.
        do_start();
        do_tick(15, 21, 1'b1);
        do_tick(15, 22, 1'b1);
        do_tick(15, 23, 1'b1);
        check("sat_len", int'(len1), 4);
        check("big_len", int'(len0), 6);
        check("sat_head", int'(hx1) * 64 + int'(hy1), 15 * 64 + 23);
        query(15, 19);
        check("sat_tail_gone", int'(hit1), 0);
        check("big_tail_kept", int'(hit0), 1);

        // Die on the neck, then start and tick together.
        do_tick(15, 22, 1'b0);
        check("neck_dead", int'(dead0), 1);
        start = 1'b1; tick = 1'b1; new_x = 6'd15; new_y = 6'd21;
        cycle();
        start = 1'b0; tick = 1'b0;
        check("restart_running", int'(run0), 1);
        check("restart_len", int'(len0), 3);
        check("restart_head", int'(hx0) * 64 + int'(hy0), 15 * 64 + 20);

        // Randomized play driven from the model's current head.
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 499) != 0);
            start = ($urandom_range(0, 79) == 0) || (mdead[0] && $urandom_range(0, 5) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            grow  = ($urandom_range(0, 3) == 0);
            hx = bd[0][0] / 64; hy = bd[0][0] % 64;
            if ($urandom_range(0, 9) == 0) begin
                new_x = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
                new_y = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
            end else begin
                dir = int'($urandom_range(0, 3));
                case (dir)
                    0: begin new_x = 6'(hx - 1); new_y = 6'(hy); end
                    1: begin new_x = 6'(hx + 1); new_y = 6'(hy); end
                    2: begin new_x = 6'(hx); new_y = 6'(hy - 1); end
                    default: begin new_x = 6'(hx); new_y = 6'(hy + 1); end
                endcase
            end
            if ($urandom_range(0, 1) == 0) begin
                j = int'($urandom_range(0, mlen[0] - 1));
                qry_x = 6'(bd[0][j] / 64); qry_y = 6'(bd[0][j] % 64);
            end else begin
                qry_x = 6'($urandom_range(0, 31)); qry_y = 6'($urandom_range(0, 41));
            end
            cycle();
        end
        rst = 1'b1; start = 1'b0; tick = 1'b0;
        cycle();
        chk_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Snake body store and collision stage, directly downstream of the head-position stage.
- On each move tick, takes the next head coordinate, checks it for wall and self collision, then shifts it into the segment array, growing by one when food was eaten.
- Feeds the current head back to the head-position stage.
- Answers per-cell occupancy queries for the VGA renderer.

Parameters:
- MAX_LEN, 32, maximum segment count (2..63).
- INIT_LEN, 3, length after start (2..MAX_LEN).
- GRID_ROWS, 30, valid x range 0..GRID_ROWS-1 (x = row; UP decrements x).
- GRID_COLS, 40, valid y range 0..GRID_COLS-1 (y = column; RIGHT increments y).
- START_X, 15, head row after start.
- START_Y, 20, head column after start; must be >= INIT_LEN-1.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset.
- i_Start  in  1  pulse: (re)initialise body and enter RUN.
- i_Tick  in  1  one-cycle move strobe.
- i_New_x  in  6  proposed head row from the head-position stage.
- i_New_y  in  6  proposed head column from the head-position stage.
- i_Grow  in  1  food eaten this move; sampled with i_Tick.
- i_Qry_x  in  6  renderer query row.
- i_Qry_y  in  6  renderer query column.
- o_Head_x  out  6  current head row (to the head-position stage).
- o_Head_y  out  6  current head column.
- o_Len  out  6  current length.
- o_Hit  out  1  queried cell is occupied (registered, 1-cycle latency).
- o_Hit_Head  out  1  queried cell is the head (registered, 1-cycle latency).
- o_Dead  out  1  high in DEAD state.
- o_Running  out  1  high in RUN state.

Behaviour:
- One clock, i_Clk. Reset is synchronous and active-low: i_Rst==0 sampled at a rising edge of i_Clk resets the block.
- Reset values:
  - state=IDLE; o_Len=INIT_LEN.
  - seg[i]=(START_X, START_Y-i) for i<INIT_LEN; all other segments 0.
  - o_Head=(START_X, START_Y); o_Hit=o_Hit_Head=o_Dead=o_Running=0.
- Storage: seg[0..MAX_LEN-1] of {x,y}. seg[0] is the head. Only seg[0..len-1] are valid.
- States:
  - IDLE: body at initial pose, ticks ignored. i_Start -> RUN.
  - RUN: process ticks as below. Collision -> DEAD.
  - DEAD: body frozen, ticks ignored, o_Dead=1. i_Start -> RUN.
- i_Start (any state): reload the initial pose and len=INIT_LEN next cycle; state=RUN.
- i_Start and i_Tick in the same cycle: start wins, tick dropped.
- Tick in RUN, all evaluated combinationally in the tick cycle:
  - Wall: i_New_x >= GRID_ROWS or i_New_y >= GRID_COLS. An upstream -1 wraps to 63 and is therefore caught.
  - Self: new head equals seg[i] for any i < len-1 when not growing (tail vacates), or any i < len when growing.
  - Collision: state<=DEAD next edge; segments and len unchanged.
  - Otherwise: seg[i]<=seg[i-1] for i>=1, seg[0]<=new.
  - If i_Grow and len<MAX_LEN: len<=len+1; the old tail is retained as the new last segment.
  - i_Grow at len==MAX_LEN: saturate, normal shift, no error.
- o_Head always reflects seg[0]. The updated head is visible the cycle after the tick.
- Query: o_Hit<=OR over i<len of (seg[i]=={i_Qry_x,i_Qry_y}); o_Hit_Head<=(seg[0]==query). Registered every cycle in all states, including DEAD, so the renderer can draw the frozen body.
- Reset mid-RUN overrides everything, ticks and start included.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined:
  - No wall death.
  - i_New_x==63 maps to GRID_ROWS-1 and i_New_x==GRID_ROWS maps to 0; same rule for y with GRID_COLS.
  - Self-collision is checked on the mapped coordinate, and the mapped coordinate is stored.
- Undefined: wall check as above; out-of-range coordinates cause DEAD.

Test Plan:
- Reset with defaults, then query (15,20), (15,18), (15,17): o_Hit=1/1/0 one cycle after each; o_Hit_Head=1 only for (15,20); o_Len=3; o_Running=0.
- i_Start, then 3 ticks with new=(15,21),(15,22),(15,23) and i_Grow on the 2nd: o_Len=4; body (15,23),(15,22),(15,21),(15,20); o_Head=(15,23).
- RUN, tick with new y=63 (left off the grid edge): o_Dead=1 next cycle; body unchanged; further ticks ignored. With SNAKE_WRAP_EN: head becomes (x,39), no death.
- Len-4 snake in a square (head (5,5), body (5,6),(6,6),(6,5)), tick with new=(6,5), grow=0: no death, tail vacates. Same setup with grow=1: o_Dead=1.
- MAX_LEN=4, grow on every tick: o_Len saturates at 4; shifting continues correctly.
- From DEAD, assert i_Start and i_Tick in the same cycle: initial pose restored, o_Running=1, o_Len=3, tick not applied.
